// File: rtl/riscv_core_pkg.sv
// Shared core package: divider state encoding and the M-extension divide op
// encoding (funct3[1:0]).
package riscv_core_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_FIX  = 2'b10,
        DIV_DONE = 2'b11
    } div_state_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

endpackage

// File: rtl/riscv_core_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle on magnitudes, sign fix-up in a single extra cycle.
module riscv_core_div
    import riscv_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic            i_div_kill,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);

    localparam int CW = $clog2(XLEN);

    function automatic logic [XLEN-1:0] f_neg_if(input logic [XLEN-1:0] a, input logic en);
        return en ? (~a + XLEN'(1)) : a;
    endfunction

    div_state_e      r_state, w_state_nxt;
    div_op_e         r_op, w_op_nxt;
    logic [XLEN-1:0] r_quo, w_quo_nxt;
    logic [XLEN-1:0] r_rem, w_rem_nxt;
    logic [XLEN-1:0] r_dvs, w_dvs_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_neg_q, w_neg_q_nxt;
    logic            r_neg_r, w_neg_r_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;

    logic            w_start, w_signed, w_rs1_neg, w_rs2_neg, w_div0, w_ovf;
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_ge;

    assign w_start   = i_div_start && !i_div_kill &&
                       (r_state == DIV_IDLE || r_state == DIV_DONE);
    assign w_signed  = ~i_div_op[0];
    assign w_rs1_neg = w_signed & i_div_rs1[XLEN-1];
    assign w_rs2_neg = w_signed & i_div_rs2[XLEN-1];
    assign w_div0    = (i_div_rs2 == '0);
    assign w_ovf     = w_signed && (i_div_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_div_rs2 == '1);

    // Borrow shows up in bit XLEN because the shifted remainder is below 2*divisor.
    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_ge    = ~w_diff[XLEN];

    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_quo_nxt    = r_quo;
        w_rem_nxt    = r_rem;
        w_dvs_nxt    = r_dvs;
        w_result_nxt = r_result;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_cnt_nxt    = r_cnt;
        if (i_div_kill) begin
            w_state_nxt = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    w_state_nxt = DIV_IDLE;
                    if (w_start) begin
                        w_op_nxt = div_op_e'(i_div_op);
                        if (w_div0) begin
                            w_result_nxt = i_div_op[1] ? i_div_rs1 : '1;
                            w_state_nxt  = DIV_DONE;
                        end else if (w_ovf) begin
                            w_result_nxt = i_div_op[1] ? '0 : i_div_rs1;
                            w_state_nxt  = DIV_DONE;
                        end else begin
                            w_quo_nxt   = f_neg_if(i_div_rs1, w_rs1_neg);
                            w_dvs_nxt   = f_neg_if(i_div_rs2, w_rs2_neg);
                            w_rem_nxt   = '0;
                            w_neg_q_nxt = w_rs1_neg ^ w_rs2_neg;
                            w_neg_r_nxt = w_rs1_neg;
                            w_cnt_nxt   = CW'(XLEN - 1);
                            w_state_nxt = DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
                    w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (r_cnt == '0) w_state_nxt = DIV_FIX;
                end
                DIV_FIX: begin
                    w_result_nxt = (r_op == OP_REM || r_op == OP_REMU) ?
                                   f_neg_if(r_rem, r_neg_r) : f_neg_if(r_quo, r_neg_q);
                    w_state_nxt  = DIV_DONE;
                end
                default: w_state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= DIV_IDLE;
            r_op     <= OP_DIV;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_quo    <= w_quo_nxt;
            r_rem    <= w_rem_nxt;
            r_dvs    <= w_dvs_nxt;
            r_result <= w_result_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_div_busy   = (r_state == DIV_CALC) || (r_state == DIV_FIX);
    assign o_div_valid  = (r_state == DIV_DONE) && !i_div_kill;
    assign o_div_result = r_result;

endmodule

// File: tb/tb_riscv_core_div.sv
// Directed self-checking bench for riscv_core_div (XLEN=32).
module tb_riscv_core_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_core_div #(.XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_div_start  (start),
        .i_div_op     (op),
        .i_div_rs1    (rs1),
        .i_div_rs2    (rs2),
        .i_div_kill   (kill),
        .o_div_busy   (busy),
        .o_div_valid  (valid),
        .o_div_result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts an op at the current negedge (cycle "start") and waits for valid.
    // lat = number of edges until valid is seen (0 = never within 40).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic busy_seen);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        lat = 0; res = 'x; busy_seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) begin
                start = 1'b0; op = ~o; rs1 = 32'h1234_5678; rs2 = 32'h0000_0003;
            end
            if (busy) busy_seen = 1'b1;
            if (valid) begin
                lat = n; res = result;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res,
                            input int exp_lat, input logic exp_busy);
        logic [31:0] res; int lat; logic bs;
        run_op(o, a, b, res, lat, bs);
        n_tests++;
        if (res !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h", name, res, exp_res);
        end
        n_tests++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_tests++;
        if (bs !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_seen: got %b expected %b", name, bs, exp_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        #1;
        n_tests++;
        if ({busy, valid, result} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b valid=%b result=%h expected all 0", busy, valid, result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        check_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        check_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 1'b1);
        check_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 1'b1);
    endtask

    task automatic test_signed;
        check_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b1);
        check_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b1);
        check_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b1);
        check_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b1);
    endtask

    task automatic test_div_zero;
        check_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        check_op("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        check_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    endtask

    task automatic test_overflow;
        check_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        check_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    endtask

    // Second op is launched in the DONE cycle of the first; then hold/pulse checks.
    task automatic test_back_to_back;
        check_op("b2b_first", 2'b01, 32'd50, 32'd5, 32'd10, 34, 1'b1);
        check_op("b2b_second", 2'b11, 32'd50, 32'd6, 32'd2, 34, 1'b1);
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_one_cycle: got %b expected 0", valid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (result !== 32'd2) begin
            n_fail++;
            $display("FAIL result_hold: got %h expected %h", result, 32'd2);
        end
    endtask

    task automatic test_kill;
        logic [31:0] prev;
        prev = result;
        start = 1'b1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        kill = 1'b1;
        @(posedge clk); @(negedge clk);
        kill = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: got busy=%b valid=%b expected 0 0", busy, valid);
        end
        n_tests++;
        if (result !== prev) begin
            n_fail++;
            $display("FAIL kill_result_kept: got %h expected %h", result, prev);
        end
        check_op("after_kill_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic seen;
        start = 1'b1; op = 2'b01; rs1 = 32'd100; rs2 = 32'd7;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, valid, result} !== 34'h0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got busy=%b valid=%b result=%h expected all 0", busy, valid, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (valid || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_activity: got %b expected 0", seen);
        end
        // First edge after release must take a start.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_op("post_reset_divu", 2'b01, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    endtask

    task automatic test_start_kill;
        logic seen;
        start = 1'b1; kill = 1'b1; op = 2'b01; rs1 = 32'd77; rs2 = 32'd0;
        seen = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); @(negedge clk);
            if (n == 1) begin start = 1'b0; kill = 1'b0; end
            if (valid || busy) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_kill: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_back_to_back;
        test_kill;
        test_reset_mid;
        test_start_kill;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_core_div.md
RISCV_CORE_DIV -- requirements
Module: riscv_core_div

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width.
REQ-002 SHALL have port: i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: i_div_start  input  1  request to start an operation.
REQ-005 SHALL have port: i_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
REQ-006 SHALL have port: i_div_rs1  input  XLEN  dividend.
REQ-007 SHALL have port: i_div_rs2  input  XLEN  divisor.
REQ-008 SHALL have port: i_div_kill  input  1  pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port: o_div_busy  output  1  operation in progress; a new start is ignored.
REQ-010 SHALL have port: o_div_valid  output  1  one-cycle pulse; o_div_result is valid.
REQ-011 SHALL have port: o_div_result  output  XLEN  quotient or remainder; feeds the EX result mux.

Function
REQ-012 SHALL implement the states IDLE, CALC, FIX and DONE.
REQ-013 SHALL accept i_div_start only in IDLE or DONE with i_div_kill=0; op, rs1 and rs2 are captured on that edge, and later input changes are ignored.
REQ-014 SHALL, on an accepted start with rs2=0 or signed overflow, go directly to DONE, so that o_div_valid is high in cycle start+1.
REQ-015 SHALL, on any other accepted start, take absolute values for signed ops, go to CALC and run XLEN restoring shift-subtract iterations (one quotient bit per cycle), then go to FIX for one cycle, then DONE: o_div_valid is high in cycle start+XLEN+2 (34 for XLEN=32).
REQ-016 SHALL, in FIX: negate the quotient when signed and the operand signs differ; negate the remainder when signed and the dividend is negative.
REQ-017 SHALL, for divide-by-zero, produce quotient all-ones and remainder = rs1, for both signed and unsigned ops.
REQ-018 SHALL, for signed overflow (DIV/REM with rs1=-2^(XLEN-1), rs2=-1), produce quotient rs1 and remainder 0.
REQ-019 SHALL compute the CALC partial remainder at XLEN+1 bits so the subtract borrow is not lost; all results are truncated to XLEN bits.
REQ-020 SHALL hold o_div_busy high in CALC and FIX only, and low in IDLE and DONE.
REQ-021 SHALL hold o_div_valid high for exactly one cycle, in DONE; DONE lasts one cycle, then goes to IDLE unless a new start is accepted.
REQ-022 SHALL keep o_div_result stable from DONE until the next accepted start completes.
REQ-023 SHALL accept a start in DONE (back-to-back operations), so the next op begins with no bubble.
REQ-024 SHALL, when i_div_kill is high in any state, go to IDLE on the next edge, suppress o_div_valid, and leave o_div_result unchanged.
REQ-025 SHALL give kill priority over a simultaneous start, so that the start is dropped.

Reset
REQ-026 SHALL, on asserting i_rst_n low, immediately force: state IDLE, o_div_busy=0, o_div_valid=0, o_div_result=0, and all internal registers 0.
REQ-027 SHALL, when reset is asserted mid-operation, discard the operation with no valid pulse after release.
REQ-028 SHALL, after reset release, accept a start on the first clock edge.

Structure
REQ-029 SHALL place the div state enum and the op encoding typedef (DIV/DIVU/REM/REMU) in the shared core package riscv_core_pkg.
REQ-030 SHALL be a single module with no sub-module; the restoring step is inline logic.
REQ-031 SHALL use one sequential process for state and datapath registers, and one combinational process for next-state and step logic.

Verification
REQ-032 SHALL verify: DIVU 100/7 -> result 14, valid at start+34; REMU 100/7 -> 2.
REQ-033 SHALL verify: DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
REQ-034 SHALL verify: DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; all with valid at start+1 and busy never high.
REQ-035 SHALL verify: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; valid at start+1.
REQ-036 SHALL verify: kill at start+10 -> no valid, busy low at start+11, and a new DIVU 9/3 started at start+11 returns 3.
REQ-037 SHALL verify: i_rst_n low at start+5 -> all outputs 0 at once and no valid after release; a start together with kill -> no operation.
